// File: rtl/cable_launch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : cable_launch_ctrl_if
// Brief   : Signal bundle between game/trajectory logic and cable_launch_ctrl.
// Rev     : 1.0
// ============================================================================
interface cable_launch_ctrl_if;
    logic       startOfFrame;
    logic       launchKey;
    logic       IsInCircular;
    logic       collision_raw;
    logic       launch_Cable;
    logic       collision;
    logic [2:0] ctrlState;
    logic       retractCause;
    logic [7:0] launchCount;

    modport master (
        output startOfFrame, launchKey, IsInCircular, collision_raw,
        input  launch_Cable, collision, ctrlState, retractCause, launchCount
    );

    modport slave (
        input  startOfFrame, launchKey, IsInCircular, collision_raw,
        output launch_Cable, collision, ctrlState, retractCause, launchCount
    );
endinterface
`default_nettype wire

// File: rtl/cable_launch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cable_launch_ctrl
// Brief   : Qualifies the launch key, reduces collision hits to one retract
//           pulse per shot and enforces a frame-based cooldown.
//           Define CABLE_AUTO_RETRACT_EN to force a retract after
//           MAX_EXTEND_FRAMES frames of extension.
// Rev     : 1.0
// ============================================================================
module cable_launch_ctrl #(
    parameter int LAUNCH_TIMEOUT_FRAMES = 8,
    parameter int MAX_EXTEND_FRAMES     = 60,
    parameter int COOLDOWN_FRAMES       = 15
) (
    input wire                 clk,
    input wire                 reset,
    cable_launch_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        READY    = 3'd0,
        LAUNCH   = 3'd1,
        EXTEND   = 3'd2,
        RETRACT  = 3'd3,
        COOLDOWN = 3'd4
    } state_t;

    localparam logic [6:0] c_LAUNCH_TO = 7'(LAUNCH_TIMEOUT_FRAMES);
    localparam logic [6:0] c_COOL      = 7'(COOLDOWN_FRAMES);
    localparam int         c_LIM_A     = (LAUNCH_TIMEOUT_FRAMES > COOLDOWN_FRAMES) ?
                                         LAUNCH_TIMEOUT_FRAMES : COOLDOWN_FRAMES;
    localparam int         c_LIM_MAX   = (c_LIM_A > MAX_EXTEND_FRAMES) ? c_LIM_A : MAX_EXTEND_FRAMES;
    // Frame counter parks at the largest limit so it can never wrap back to a match.
    localparam logic [6:0] c_FC_CEIL   = (c_LIM_MAX > 127) ? 7'd127 : 7'(c_LIM_MAX);
`ifdef CABLE_AUTO_RETRACT_EN
    localparam logic [6:0] c_MAX_EXT   = 7'(MAX_EXTEND_FRAMES);
`endif

    state_t     state_q, state_d;
    logic [6:0] frame_cnt_q, frame_cnt_d;
    logic [7:0] launch_count_q, launch_count_d;
    logic       retract_cause_q, retract_cause_d;
    logic       collision_q, collision_d;
    logic       launch_cable_q, launch_cable_d;
    logic       key_d_q, key_d_d;
    logic       key_edge_q, key_edge_d;
    logic       circ_q, circ_d;
    logic       hit_q, hit_d;
    logic       w_counting;

    assign w_counting = (state_q == LAUNCH) || (state_q == EXTEND) || (state_q == COOLDOWN);

    always_comb begin
        state_d         = state_q;
        frame_cnt_d     = frame_cnt_q;
        launch_count_d  = launch_count_q;
        retract_cause_d = retract_cause_q;
        collision_d     = 1'b0;
        key_d_d         = bus.launchKey;
        key_edge_d      = bus.launchKey & ~key_d_q;
        circ_d          = bus.IsInCircular;
        hit_d           = bus.collision_raw;

        unique case (state_q)
            READY: begin
                if (key_edge_q && circ_q) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                if (!circ_q) begin
                    state_d = EXTEND;
                    if (launch_count_q != 8'hFF) begin
                        launch_count_d = launch_count_q + 8'd1;
                    end
                end else if (frame_cnt_q == c_LAUNCH_TO) begin
                    state_d = READY;
                end
            end
            EXTEND: begin
                // Object hit takes priority over the extension timeout.
                if (hit_q) begin
                    state_d         = RETRACT;
                    collision_d     = 1'b1;
                    retract_cause_d = 1'b0;
                end
`ifdef CABLE_AUTO_RETRACT_EN
                else if (frame_cnt_q == c_MAX_EXT) begin
                    state_d         = RETRACT;
                    collision_d     = 1'b1;
                    retract_cause_d = 1'b1;
                end
`endif
                else if (circ_q) begin
                    state_d = COOLDOWN;
                end
            end
            RETRACT: begin
                if (circ_q) begin
                    state_d = COOLDOWN;
                end
            end
            COOLDOWN: begin
                if (frame_cnt_q == c_COOL) begin
                    state_d = READY;
                end
            end
            default: begin
                state_d = READY;
            end
        endcase

        if (state_d != state_q) begin
            frame_cnt_d = 7'd0;
        end else if (bus.startOfFrame && w_counting && (frame_cnt_q != c_FC_CEIL)) begin
            frame_cnt_d = frame_cnt_q + 7'd1;
        end

        launch_cable_d = (state_d == LAUNCH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= READY;
            frame_cnt_q     <= 7'd0;
            launch_count_q  <= 8'd0;
            retract_cause_q <= 1'b0;
            collision_q     <= 1'b0;
            launch_cable_q  <= 1'b0;
            key_d_q         <= 1'b0;
            key_edge_q      <= 1'b0;
            circ_q          <= 1'b0;
            hit_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            frame_cnt_q     <= frame_cnt_d;
            launch_count_q  <= launch_count_d;
            retract_cause_q <= retract_cause_d;
            collision_q     <= collision_d;
            launch_cable_q  <= launch_cable_d;
            key_d_q         <= key_d_d;
            key_edge_q      <= key_edge_d;
            circ_q          <= circ_d;
            hit_q           <= hit_d;
        end
    end

    assign bus.launch_Cable = launch_cable_q;
    assign bus.collision    = collision_q;
    assign bus.ctrlState    = state_q;
    assign bus.retractCause = retract_cause_q;
    assign bus.launchCount  = launch_count_q;

endmodule
`default_nettype wire
